// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between a set of ALU clients and alu_share_arbiter.
//   req_valid/req_ready : per-requester request handshake
//   req_a/req_b/req_op  : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_result/rsp_zero : registered result and zero flag shared by all requesters
// slave  modport : arbiter side
// master modport : requester side
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters.
// One operation is in flight at a time: IDLE (arbitrate/accept) -> ISSUE
// (drive ALU, capture result) -> RESP (hold result until the owner accepts).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : request/response bundle (slave side)
//   alu_a/b/op   : operands to the external ALU, zero outside ISSUE
//   alu_result   : ALU result, combinational from alu_*
//   alu_zero     : ALU zero flag
//   busy         : FSM is not in IDLE
//   done_count   : completed responses, wraps modulo 2^CNT_W
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_share_arbiter_if.slave       bus,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [OP_W-1:0]          alu_op,
    input  logic [DATA_W-1:0]        alu_result,
    input  logic                     alu_zero,
    output logic                     busy,
    output logic [CNT_W-1:0]         done_count
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [OP_W-1:0]    r_op;
    logic [DATA_W-1:0]  r_result;
    logic               r_zero;
    logic [CNT_W-1:0]   r_done_count;

    logic               w_win_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic [DATA_W-1:0]  w_sel_a;
    logic [DATA_W-1:0]  w_sel_b;
    logic [OP_W-1:0]    w_sel_op;
    int                 w_idx;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_rsp_valid;
    logic               w_rsp_accept;

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_op    = '0;
        w_idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_win_found && bus.req_valid[w_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDX_W'(w_idx);
                w_sel_a     = bus.req_a[w_idx*DATA_W +: DATA_W];
                w_sel_b     = bus.req_b[w_idx*DATA_W +: DATA_W];
                w_sel_op    = bus.req_op[w_idx*OP_W +: OP_W];
            end else begin
                w_win_found = w_win_found;
            end
        end
    end

    // Next-state logic and handshake/ALU outputs.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_rsp_valid  = '0;
        w_rsp_accept = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = '0;
        case (r_state)
            IDLE: begin
                // ready only goes to a valid winner, so ready implies handshake
                if (w_win_found) begin
                    w_req_ready[w_win_idx] = 1'b1;
                    w_next_state           = ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                alu_a        = r_a;
                alu_b        = r_b;
                alu_op       = r_op;
                w_next_state = RESP;
            end
            RESP: begin
                w_rsp_valid[r_grant] = 1'b1;
                // only the granted requester's rsp_ready is looked at
                if (bus.rsp_ready[r_grant]) begin
                    w_rsp_accept = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, operand latch, result capture and completion bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_win_found) begin
                r_grant <= w_win_idx;
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_op    <= w_sel_op;
            end
            if (r_state == ISSUE) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
            if (w_rsp_accept) begin
                r_last_grant <= r_grant;
                r_done_count <= r_done_count + CNT_W'(1);
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_result = r_result;
    assign bus.rsp_zero   = r_zero;
    assign busy           = (r_state != IDLE);
    assign done_count     = r_done_count;
endmodule
